// File: rtl/cska_seq_ctrl.sv
// Sequential add/subtract: one 4-bit carry-skip slice per cycle, LSB slice first.
// Latency: NIBBLES RUN cycles after start, then a one-cycle done pulse.
// Backpressure: start is ignored while busy; a start in the done cycle chains directly.
module carry_skip_adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = A ^ B;
        g    = A & B;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum  = p ^ c[3:0];
        // All four bits propagating: the block carry bypasses the ripple chain.
        cout = (&p) ? cin : c[4];
    end
endmodule

module cska_seq_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic          last_slice;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_nx;
    logic [IW-1:0] idx;
    logic          carry_r;
    logic [3:0]    a_sl;
    logic [3:0]    b_sl;
    logic [3:0]    sum_sl;
    logic          sl_cout;
    logic          ovf_nx;

    assign last_slice = (idx == LAST);
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign a_sl       = a_r[{idx, 2'b00} +: 4];
    assign b_sl       = b_r[{idx, 2'b00} +: 4];

    carry_skip_adder_4bit u_slice (
        .A    (a_sl),
        .B    (b_sl),
        .cin  (carry_r),
        .sum  (sum_sl),
        .cout (sl_cout)
    );

    always_comb begin
        acc_nx = acc;
        acc_nx[{idx, 2'b00} +: 4] = sum_sl;
        // b_r already holds ~b for subtraction, so this is the usual same-sign test.
        ovf_nx = (a_r[W-1] == b_r[W-1]) && (acc_nx[W-1] != a_r[W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                accept  = start;
                state_d = start ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            idx     <= '0;
            carry_r <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub;
            idx     <= '0;
        end else if (state_q == RUN) begin
            acc     <= acc_nx;
            carry_r <= sl_cout;
            idx     <= last_slice ? '0 : idx + IW'(1);
            if (last_slice) begin
                result <= acc_nx;
                cout   <= sl_cout;
                ovf    <= ovf_nx;
            end
        end
    end
endmodule

// File: tb/tb_cska_seq_ctrl.sv
// Scoreboard bench for cska_seq_ctrl: a plain-arithmetic model predicts each accepted op.
module tb_cska_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   busy_until = -1;
    int   checks = 0;
    int   failures = 0;
    bit   end_req = 1'b0;

    cska_seq_ctrl #(.NIBBLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input int due);
        exp_t       e;
        logic [W:0] wide;
        if (!s) begin
            wide = {1'b0, x} + {1'b0, y};
            e.co = wide[W];
            e.ov = (x[W-1] == y[W-1]) && (wide[W-1] != x[W-1]);
        end else begin
            wide = {1'b0, x} - {1'b0, y};
            e.co = (x >= y);
            e.ov = (x[W-1] != y[W-1]) && (wide[W-1] != x[W-1]);
        end
        e.res = wide[W-1:0];
        e.due = due;
        return e;
    endfunction

    // Reference timing: accepted at edge P, busy for N cycles, done seen after edge P+N.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_until = -1;
        end else begin
            cyc = cyc + 1;
            if (start && (cyc - 1 > busy_until)) begin
                q.push_back(model(sub, a, b, cyc + N));
                busy_until = cyc + N - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    logic [W-1:0] last_res = '0;
    logic         last_co = 1'b0;
    logic         last_ov = 1'b0;

    always begin
        @(negedge clk or negedge rst_n or posedge end_req);
        if (end_req) begin
            chk("queue_drained", W'(q.size()), '0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else if (!rst_n) begin
            #1;
            chk("rst_busy", W'(busy), '0);
            chk("rst_done", W'(done), '0);
            chk("rst_result", result, '0);
            chk("rst_cout", W'(cout), '0);
            chk("rst_ovf", W'(ovf), '0);
            q.delete();
            last_res = '0;
            last_co  = 1'b0;
            last_ov  = 1'b0;
        end else begin
            logic exp_done;
            exp_done = (q.size() > 0) && (q[0].due == cyc);
            chk("busy", W'(busy), W'(cyc <= busy_until));
            chk("done", W'(done), W'(exp_done));
            if (exp_done) begin
                chk("result", result, q[0].res);
                chk("cout", W'(cout), W'(q[0].co));
                chk("ovf", W'(ovf), W'(q[0].ov));
                last_res = q[0].res;
                last_co  = q[0].co;
                last_ov  = q[0].ov;
                void'(q.pop_front());
            end else begin
                chk("hold_result", result, last_res);
                chk("hold_cout", W'(cout), W'(last_co));
                chk("hold_ovf", W'(ovf), W'(last_ov));
            end
        end
    end

    task automatic step(input bit st, input bit sb, input logic [W-1:0] aa, input logic [W-1:0] bb);
        start = st;
        sub   = sb;
        a     = aa;
        b     = bb;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles still wiggle operands to show they are ignored.
    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(16'h7FFF);
            3:       return W'(16'h8000);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        step(1'b1, 1'b0, 16'hFFFF, 16'h0001); idle(N + 1);
        step(1'b1, 1'b0, 16'h7FFF, 16'h0001); idle(N + 1);
        step(1'b1, 1'b1, 16'h0002, 16'h0005); idle(N + 1);
        step(1'b1, 1'b1, 16'h0005, 16'h0002); idle(N + 1);

        // Start during RUN is dropped; start in the done cycle chains.
        step(1'b1, 1'b0, 16'h0F0F, 16'h0101);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b1, 16'hAAAA, 16'h5555);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 16'h1234, 16'h1111);
        idle(N + 1);

        // Reset mid-RUN, then a clean operation.
        step(1'b1, 1'b0, 16'h4321, 16'h1111);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h0101, 16'h0202);
        idle(N + 1);

        repeat (400) begin
            step($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), pick(), pick());
        end
        idle(N + 3);
        end_req = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/cska_seq_ctrl.md
CSKA_SEQ_CTRL -- requirements
Module: cska_seq_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation; sampled on the clk edge.
REQ-005 SHALL have port sub, input, 1, operation select: 0 = A+B, 1 = A-B; sampled with start.
REQ-006 SHALL have port a, input, W, operand A; sampled with start.
REQ-007 SHALL have port b, input, W, operand B; sampled with start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port result, output, W, last completed sum or difference.
REQ-011 SHALL have port cout, output, 1, carry out of the MSB slice of the last completed operation.
REQ-012 SHALL have port ovf, output, 1, two's-complement overflow of the last completed operation.

Function
REQ-013 SHALL compute every slice with one instance of carry_skip_adder_4bit (ports A, B, cin, sum, cout); it is reused once per cycle.
REQ-014 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-015 IDLE: on start=1 at an edge, SHALL latch a into a_r and (sub ? ~b : b) into b_r; set carry_r = sub and slice index idx = 0; go to RUN.
REQ-016 RUN: each edge SHALL feed a_r[4*idx+3:4*idx], b_r[4*idx+3:4*idx] and carry_r to the adder.
REQ-017 RUN: each edge SHALL write the adder sum into acc[4*idx+3:4*idx], load carry_r with the adder cout, and increment idx.
REQ-018 RUN: on the edge that processes slice NIBBLES-1, SHALL go to DONE.
REQ-019 On that same edge, SHALL copy the completed value into result, the final carry into cout, and the computed overflow into ovf.
REQ-020 SHALL compute ovf = (a_r[W-1] == b_r[W-1]) && (final sum[W-1] != a_r[W-1]), where b_r is the post-inversion operand.
REQ-021 DONE: SHALL hold done=1 for exactly one cycle, then return to IDLE.
REQ-022 DONE: start=1 SHALL be accepted exactly as in IDLE and go directly to RUN, giving back-to-back operation with no idle cycle.
REQ-023 Latency: with start sampled at edge T0, RUN SHALL occupy edges T1..T_NIBBLES and done SHALL be high in the cycle after edge T_NIBBLES.
REQ-024 busy SHALL be 1 exactly while the FSM is in RUN.
REQ-025 start while busy=1 SHALL be ignored: no latch, no state change, operands unaffected.
REQ-026 result, cout and ovf SHALL hold their previous values throughout RUN and update only at completion.
REQ-027 result SHALL wrap modulo 2^W; for subtraction, cout=1 means no borrow (A >= B unsigned).
REQ-028 sub, a and b SHALL be don't-care in every cycle in which start is not accepted.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, idx=0 and carry_r=0.
REQ-030 rst_n=0 SHALL asynchronously clear a_r, b_r and acc to 0.
REQ-031 rst_n=0 SHALL asynchronously clear busy, done, result, cout and ovf to 0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation; no done pulse, and result stays 0.
REQ-033 After rst_n deasserts, the first start SHALL be accepted at the next edge.

Verification
REQ-034 Reset: rst_n=0 -> busy=0, done=0, result=0x0000, cout=0, ovf=0, with no clock edge needed.
REQ-035 Add wrap: a=0xFFFF, b=0x0001, sub=0 -> after 4 RUN cycles, done=1, result=0x0000, cout=1, ovf=0.
REQ-036 Signed overflow: a=0x7FFF, b=0x0001, sub=0 -> result=0x8000, cout=0, ovf=1.
REQ-037 Subtract with borrow: a=0x0002, b=0x0005, sub=1 -> result=0xFFFD, cout=0, ovf=0; then a=0x0005, b=0x0002, sub=1 -> result=0x0003, cout=1.
REQ-038 Handshake: start pulsed at RUN cycle 2 -> ignored; start held on the done cycle with a=0x1234, b=0x1111, sub=0 -> busy at the next cycle, then result=0x2345 five cycles later.
REQ-039 Mid-operation reset: rst_n=0 during RUN cycle 2 -> immediately IDLE with all outputs 0; a new start then completes normally.
